// File: rtl/inst_ram_loader_pkg.sv
// Shared definitions for the boot-time instruction RAM loader.
package inst_ram_loader_pkg;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;
  // Word count and write pointer width; must hold N = 65535 plus one.
  localparam int CntW        = 17;

  typedef enum logic [2:0] {
    LdHdrHi,
    LdHdrLo,
    LdData,
    LdCsum,
    LdDone,
    LdErr
  } ld_state_e;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/inst_ram_loader_ram.sv
// Instruction RAM: synchronous write port, combinational read port.
module inst_ram
  import inst_ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [InstBus-1:0]    i_wdata,
  input  logic                  i_ce,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [InstBus-1:0]    o_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [InstBus-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_data = i_ce ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/inst_ram_loader.sv
// Loads a checksummed byte-stream image into instruction RAM, then releases the core.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic                   rom_ce_i,
  input  logic [InstAddrBus-1:0] rom_addr_i,
  output logic [InstBus-1:0]     rom_inst_o,
  output logic                   cpu_rst_o,
  output logic                   load_done_o,
  output logic                   load_err_o
);

  localparam longint unsigned DEPTH = 64'd1 << ADDR_WIDTH;

  ld_state_e r_state;
  ld_state_e w_state_nxt;

  logic [7:0]            r_cnt_hi;
  logic [CntW-1:0]       r_count;
  logic [CntW-1:0]       r_waddr;
  logic [1:0]            r_bidx;
  logic [23:0]           r_shift;
  logic [7:0]            r_sum;
  logic                  r_ready;
  logic                  r_cpu_rst;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic [7:0]            w_sum_nxt;
  logic [CntW-1:0]       w_hdr_n;
  logic                  w_oversize;
  logic [CntW-1:0]       w_waddr_inc;
  logic                  w_we;
  logic [InstBus-1:0]    w_wdata;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [ADDR_WIDTH-1:0] w_ram_raddr;
  logic                  w_unused_addr;

  assign w_accept    = rx_valid_i & r_ready;
  assign w_sum_nxt   = csum_add(r_sum, rx_data_i);
  assign w_hdr_n     = {1'b0, r_cnt_hi, rx_data_i};
  assign w_oversize  = 64'(w_hdr_n) > DEPTH;
  assign w_waddr_inc = r_waddr + CntW'(1);
  assign w_we        = w_accept && (r_state == LdData) && (r_bidx == 2'd3);
  assign w_wdata     = {r_shift, rx_data_i};
  assign w_ram_waddr = ADDR_WIDTH'(r_waddr);
  assign w_ram_raddr = rom_addr_i[ADDR_WIDTH+1:2];
  // Byte-lane and out-of-range fetch address bits are intentionally ignored.
  assign w_unused_addr = ^rom_addr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LdHdrHi;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LdHdrHi: if (w_accept) w_state_nxt = LdHdrLo;
      LdHdrLo: begin
        if (w_accept) begin
          if (w_oversize)          w_state_nxt = LdErr;
          else if (w_hdr_n == '0)  w_state_nxt = LdCsum;
          else                     w_state_nxt = LdData;
        end
      end
      LdData:  if (w_we && (w_waddr_inc == r_count)) w_state_nxt = LdCsum;
      LdCsum: begin
        if (w_accept) begin
          w_state_nxt = (w_sum_nxt == 8'h00) ? LdDone : LdErr;
        end
      end
      LdDone:  w_state_nxt = LdDone;
      LdErr:   w_state_nxt = LdErr;
      default: w_state_nxt = LdErr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_hi <= '0;
      r_count  <= '0;
      r_waddr  <= '0;
      r_bidx   <= '0;
      r_shift  <= '0;
      r_sum    <= '0;
    end else if (w_accept) begin
      r_sum <= w_sum_nxt;
      case (r_state)
        LdHdrHi: r_cnt_hi <= rx_data_i;
        LdHdrLo: r_count  <= w_hdr_n;
        LdData: begin
          r_shift <= {r_shift[15:0], rx_data_i};
          r_bidx  <= r_bidx + 2'd1;
          if (r_bidx == 2'd3) begin
            r_waddr <= w_waddr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready   <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ready   <= (w_state_nxt != LdDone) && (w_state_nxt != LdErr);
      r_cpu_rst <= (w_state_nxt != LdDone);
      r_done    <= (w_state_nxt == LdDone);
      r_err     <= (w_state_nxt == LdErr);
    end
  end

  assign rx_ready_o  = r_ready;
  assign cpu_rst_o   = r_cpu_rst;
  assign load_done_o = r_done;
  assign load_err_o  = r_err;

  inst_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_inst_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_ram_waddr),
    .i_wdata(w_wdata),
    .i_ce   (rom_ce_i),
    .i_raddr(w_ram_raddr),
    .o_data (rom_inst_o)
  );

endmodule
